// File: rtl/register_file_param.sv
// -----------------------------------------------------------------------------
// register_file_param
//
// Parameterised flop-based register file with two combinational read ports,
// one write port, optional write-to-read forwarding, an optional hard-wired
// zero register and a sequential "clear all" engine.
//
// Parameters
//   DATA_W   : data width in bits
//   ADDR_W   : address width; the file holds DEPTH = 2**ADDR_W registers
//   ZERO_REG : 1 -> register 0 always reads zero and is never written
//   BYPASS   : 1 -> a write in progress is forwarded to matching read ports
//
// Ports
//   Clk         : single clock, all state changes on the rising edge
//   Rst         : synchronous active-high reset (zeroes every register)
//   Write_En    : write strobe
//   Write_Addr  : write register index
//   Write_Data  : write data
//   Read_Addr_A : read port A index
//   Read_Addr_B : read port B index
//   Clear_Req   : start a sequential clear of every register
//   OutA / OutB : combinational read data
//   Clear_Busy  : high while the clear sequence walks the file
//   Clear_Done  : single-cycle pulse after the last register was cleared
// -----------------------------------------------------------------------------
module register_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Write_En,
    input  logic [ADDR_W-1:0] Write_Addr,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [ADDR_W-1:0] Read_Addr_A,
    input  logic [ADDR_W-1:0] Read_Addr_B,
    input  logic              Clear_Req,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB,
    output logic              Clear_Busy,
    output logic              Clear_Done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_clr_done;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_clr_last;
    logic              w_wr_idle;
    logic              w_store_en;

    // The clear engine reaches the last register when the counter is all ones.
    assign w_clr_last = (r_clr_cnt == {ADDR_W{1'b1}});

    // Register 0 is never stored when it is hard-wired to zero.
    assign w_store_en = w_wr_idle &&
                        !((ZERO_REG != 0) && (Write_Addr == '0));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Clear_Req is only looked at in IDLE, so a
    // request during a running clear neither restarts nor extends it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Clear_Req) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Writes (and forwarding) are only honoured in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        Clear_Busy = (r_state == ST_CLEAR);
        Clear_Done = r_clr_done;
        w_wr_idle  = Write_En && (r_state == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Clear counter and completion pulse. The counter rests at zero in
    // IDLE so that entering CLEAR always starts at register 0.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_clr_cnt  <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= (r_state == ST_CLEAR) && w_clr_last;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Reset has to zero every entry in one edge, so this is a
    // flop array rather than a RAM.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_regs[r_clr_cnt] <= '0;
        end else if (w_store_en) begin
            r_regs[Write_Addr] <= Write_Data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports (0 = A, 1 = B). Zero-register masking is applied after
    // forwarding so address 0 reads zero even during a bypassed write.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;

            assign w_addr = (gi == 0) ? Read_Addr_A : Read_Addr_B;

            always_comb begin
                w_data = r_regs[w_addr];
                if ((BYPASS != 0) && w_wr_idle && (w_addr == Write_Addr)) begin
                    w_data = Write_Data;
                end
                if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_data = '0;
                end
            end
        end
    endgenerate

    assign OutA = g_rd[0].w_data;
    assign OutB = g_rd[1].w_data;

endmodule

// File: tb/tb_register_file_param.sv
// -----------------------------------------------------------------------------
// tb_register_file_param
//
// Three instances of register_file_param:
//   u_dut0 : defaults (16-bit, 8 regs, BYPASS=1, ZERO_REG=0)
//   u_dut1 : same stimulus as u_dut0, but BYPASS=0 and ZERO_REG=1
//   u_wide : 32-bit, 16 regs, defaults otherwise, own stimulus
// Each cycle the expected outputs, computed from a small behavioural model,
// are pushed to a scoreboard queue; at the falling edge they are popped and
// compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_register_file_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- narrow instances (shared stimulus) ----------------
    logic        s_rst, s_we, s_clr;
    logic [2:0]  s_wa, s_ra, s_rb;
    logic [15:0] s_wd;
    logic [15:0] o0a, o0b, o1a, o1b;
    logic        o0busy, o0done, o1busy, o1done;

    // ---------------- wide instance ----------------
    logic        w_rst, w_we, w_clr;
    logic [3:0]  w_wa, w_ra, w_rb;
    logic [31:0] w_wd;
    logic [31:0] owa, owb;
    logic        owbusy, owdone;

    register_file_param u_dut0 (
        .Clk(clk), .Rst(s_rst), .Write_En(s_we), .Write_Addr(s_wa),
        .Write_Data(s_wd), .Read_Addr_A(s_ra), .Read_Addr_B(s_rb),
        .Clear_Req(s_clr), .OutA(o0a), .OutB(o0b),
        .Clear_Busy(o0busy), .Clear_Done(o0done)
    );

    register_file_param #(.ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .Clk(clk), .Rst(s_rst), .Write_En(s_we), .Write_Addr(s_wa),
        .Write_Data(s_wd), .Read_Addr_A(s_ra), .Read_Addr_B(s_rb),
        .Clear_Req(s_clr), .OutA(o1a), .OutB(o1b),
        .Clear_Busy(o1busy), .Clear_Done(o1done)
    );

    register_file_param #(.DATA_W(32), .ADDR_W(4)) u_wide (
        .Clk(clk), .Rst(w_rst), .Write_En(w_we), .Write_Addr(w_wa),
        .Write_Data(w_wd), .Read_Addr_A(w_ra), .Read_Addr_B(w_rb),
        .Clear_Req(w_clr), .OutA(owa), .OutB(owb),
        .Clear_Busy(owbusy), .Clear_Done(owdone)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    // ---------------- models ----------------
    logic [15:0] m0 [8];
    logic [15:0] m1 [8];
    logic        m_busy, m_done;
    int          m_cnt;

    logic [31:0] mw [16];
    logic        mw_busy, mw_done;
    int          mw_cnt;
    int          w_busy_seen;

    // u_dut0: forwarding on, no zero register
    function automatic logic [15:0] exp0(input logic [2:0] a);
        if (s_we && !m_busy && a == s_wa) return s_wd;
        return m0[a];
    endfunction

    // u_dut1: no forwarding, register 0 hard-wired to zero
    function automatic logic [15:0] exp1(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        return m1[a];
    endfunction

    function automatic logic [31:0] expw(input logic [3:0] a);
        if (w_we && !mw_busy && a == w_wa) return w_wd;
        return mw[a];
    endfunction

    // One cycle on the narrow instances: expectations, sample, clock edge,
    // model update from the inputs seen at that edge, then new inputs may go.
    task automatic step(input string tag);
        sb_push({tag, ".a0"},    32'(exp0(s_ra)));
        sb_push({tag, ".b0"},    32'(exp0(s_rb)));
        sb_push({tag, ".busy0"}, 32'(m_busy));
        sb_push({tag, ".done0"}, 32'(m_done));
        sb_push({tag, ".a1"},    32'(exp1(s_ra)));
        sb_push({tag, ".b1"},    32'(exp1(s_rb)));
        sb_push({tag, ".busy1"}, 32'(m_busy));
        sb_push({tag, ".done1"}, 32'(m_done));
        @(negedge clk);
        sb_pop(32'(o0a));
        sb_pop(32'(o0b));
        sb_pop(32'(o0busy));
        sb_pop(32'(o0done));
        sb_pop(32'(o1a));
        sb_pop(32'(o1b));
        sb_pop(32'(o1busy));
        sb_pop(32'(o1done));
        $display("txn %-12s ra=%0d rb=%0d A0=%04h B0=%04h A1=%04h B1=%04h busy=%0b done=%0b",
                 tag, s_ra, s_rb, o0a, o0b, o1a, o1b, o0busy, o0done);
        @(posedge clk);
        if (s_rst) begin
            for (int i = 0; i < 8; i++) begin
                m0[i] = '0;
                m1[i] = '0;
            end
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
        end else if (m_busy) begin
            m0[m_cnt] = '0;
            m1[m_cnt] = '0;
            m_done = (m_cnt == 7);
            m_busy = (m_cnt != 7);
            m_cnt  = (m_cnt + 1) % 8;
        end else begin
            m_done = 1'b0;
            if (s_we) begin
                m0[s_wa] = s_wd;
                if (s_wa != 3'd0) m1[s_wa] = s_wd;
            end
            if (s_clr) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        #1;
    endtask

    task automatic step_w(input string tag);
        sb_push({tag, ".aw"},    expw(w_ra));
        sb_push({tag, ".bw"},    expw(w_rb));
        sb_push({tag, ".busyw"}, 32'(mw_busy));
        sb_push({tag, ".donew"}, 32'(mw_done));
        @(negedge clk);
        sb_pop(owa);
        sb_pop(owb);
        sb_pop(32'(owbusy));
        sb_pop(32'(owdone));
        if (owbusy) w_busy_seen++;
        $display("txn %-12s ra=%0d rb=%0d AW=%08h BW=%08h busy=%0b done=%0b",
                 tag, w_ra, w_rb, owa, owb, owbusy, owdone);
        @(posedge clk);
        if (w_rst) begin
            for (int i = 0; i < 16; i++) mw[i] = '0;
            mw_busy = 1'b0;
            mw_done = 1'b0;
            mw_cnt  = 0;
        end else if (mw_busy) begin
            mw[mw_cnt] = '0;
            mw_done = (mw_cnt == 15);
            mw_busy = (mw_cnt != 15);
            mw_cnt  = (mw_cnt + 1) % 16;
        end else begin
            mw_done = 1'b0;
            if (w_we) mw[w_wa] = w_wd;
            if (w_clr) begin
                mw_busy = 1'b1;
                mw_cnt  = 0;
            end
        end
        #1;
    endtask

    logic [15:0] wtab [8];

    initial begin
        wtab[0] = 16'h0012; wtab[1] = 16'h0034; wtab[2] = 16'h0056; wtab[3] = 16'h0078;
        wtab[4] = 16'h009A; wtab[5] = 16'h00BC; wtab[6] = 16'h00DE; wtab[7] = 16'h00F0;

        for (int i = 0; i < 8; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        for (int i = 0; i < 16; i++) mw[i] = '0;
        m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
        mw_busy = 1'b0; mw_done = 1'b0; mw_cnt = 0;
        w_busy_seen = 0;

        s_rst = 1'b1; s_we = 1'b0; s_clr = 1'b0;
        s_wa = '0; s_ra = '0; s_rb = '0; s_wd = '0;
        w_rst = 1'b1; w_we = 1'b0; w_clr = 1'b0;
        w_wa = '0; w_ra = '0; w_rb = '0; w_wd = '0;

        // First edge applies reset; outputs are defined from then on.
        @(posedge clk);
        #1;
        step("reset");
        s_rst = 1'b0;
        w_rst = 1'b0;

        // Write sweep with port A watching the written address (forwarding).
        for (int i = 0; i < 8; i++) begin
            s_we = 1'b1; s_wa = 3'(i); s_wd = wtab[i];
            s_ra = 3'(i); s_rb = 3'((i + 1) % 8);
            step($sformatf("wr%0d", i));
        end
        s_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_ra = 3'(i); s_rb = 3'd0;
            step($sformatf("rdA%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            s_ra = 3'd0; s_rb = 3'(i);
            step($sformatf("rdB%0d", i));
        end

        // Same-cycle forwarding vs old value.
        s_we = 1'b1; s_wa = 3'd5; s_wd = 16'hBEEF; s_ra = 3'd5; s_rb = 3'd5;
        step("byp5");
        s_we = 1'b0;
        step("byp5_after");

        // Writes to register 0 (zero register on u_dut1).
        s_we = 1'b1; s_wa = 3'd0; s_wd = 16'hFFFF; s_ra = 3'd0; s_rb = 3'd0;
        step("zr_wr");
        s_we = 1'b0;
        step("zr_after");

        // Write and clear request together, then writes/requests while busy.
        s_we = 1'b1; s_wa = 3'd2; s_wd = 16'h5555; s_clr = 1'b1; s_ra = 3'd2; s_rb = 3'd7;
        step("wr_clr");
        for (int k = 0; k < 8; k++) begin
            s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hAAAA;
            s_ra = 3'(k); s_rb = 3'd7; s_clr = (k == 3);
            step($sformatf("clr1_%0d", k));
        end
        // Done cycle: a new request starts a fresh clear.
        s_we = 1'b0; s_clr = 1'b1; s_ra = 3'd7; s_rb = 3'd2;
        step("done_restart");
        s_clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_ra = 3'(k); s_rb = 3'(7 - k);
            step($sformatf("clr2_%0d", k));
        end
        step("clr2_done");

        // Refill, start a clear and reset it on its third cycle.
        for (int i = 0; i < 8; i++) begin
            s_we = 1'b1; s_wa = 3'(i); s_wd = 16'h1000 + 16'(i * 16'h0111);
            s_ra = 3'(i); s_rb = 3'(i);
            step($sformatf("refill%0d", i));
        end
        s_we = 1'b0; s_clr = 1'b1;
        step("clr3_start");
        s_clr = 1'b0;
        step("clr3_0");
        step("clr3_1");
        s_rst = 1'b1; s_we = 1'b1; s_wa = 3'd6; s_wd = 16'h7777;
        step("clr3_2_rst");
        s_rst = 1'b0; s_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_ra = 3'(i); s_rb = 3'(7 - i);
            step($sformatf("post_rst%0d", i));
        end

        // Wide instance: 16 x 32-bit.
        for (int i = 0; i < 16; i++) begin
            w_we = 1'b1; w_wa = 4'(i); w_wd = 32'hDEADBEEF ^ (32'(i) * 32'h01010101);
            w_ra = 4'(i); w_rb = 4'd0;
            step_w($sformatf("wwr%0d", i));
        end
        w_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_ra = 4'(i); w_rb = 4'(15 - i);
            step_w($sformatf("wrd%0d", i));
        end
        w_clr = 1'b1;
        step_w("wclr_start");
        w_clr = 1'b0;
        w_busy_seen = 0;
        for (int k = 0; k < 18; k++) begin
            w_ra = 4'(k % 16); w_rb = 4'd15;
            step_w($sformatf("wclr_%0d", k));
        end
        check_eq("wide_clear_len", 32'(w_busy_seen), 32'd16);
        for (int i = 0; i < 16; i++) begin
            w_ra = 4'(i); w_rb = 4'(i);
            step_w($sformatf("wzero%0d", i));
        end

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
